// File: rtl/sum_sq_acc.sv
// rtl/sum_sq_acc.sv - saturating sum-of-squares accumulator with start/valid/ready handshakes
module sum_sq_acc #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_sum,
  output logic              out_ovf,
  input  logic              out_ready,
  output logic              busy
);

  localparam int SQ_W  = 2 * DATA_W;
  // Wide enough for both operands plus one carry bit, so any carry out of
  // the OUT_W result range is visible regardless of the parameter choice.
  localparam int SUM_W = ((OUT_W > SQ_W) ? OUT_W : SQ_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [OUT_W-1:0]    acc;
  logic [3:0]          cnt;
  logic                ovf;
  logic                beat;
  logic                launch;
  logic [SQ_W-1:0]     sq;
  logic [SUM_W-1:0]    sum;
  logic                sum_carry;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    beat      = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = (len == 4'd0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          beat = 1'b1;
          if (cnt == 4'd1) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Square the incoming sample and add it to the running total with a carry bit
  always_comb begin
    sq        = SQ_W'(in_data) * SQ_W'(in_data);
    sum       = SUM_W'(acc) + SUM_W'(sq);
    sum_carry = |sum[SUM_W-1:OUT_W];
  end

  // Accumulator, remaining-sample counter and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= 4'd0;
      ovf <= 1'b0;
    end else if (launch) begin
      acc <= '0;
      cnt <= len;
      ovf <= 1'b0;
    end else if (beat) begin
      cnt <= cnt - 4'd1;
      if (sum_carry) begin
        acc <= {OUT_W{1'b1}};
        ovf <= 1'b1;
      end else begin
        acc <= sum[OUT_W-1:0];
      end
    end
  end

  // The result registers double as the output, so the last result persists in IDLE
  always_comb begin
    out_sum = acc;
    out_ovf = ovf;
  end

endmodule

// File: tb/tb_sum_sq_acc.sv
// tb/tb_sum_sq_acc.sv - directed self-checking bench for sum_sq_acc
module tb_sum_sq_acc;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic        out_ready;
  logic        busy;

  int pass_cnt;
  int total_cnt;

  sum_sq_acc #(.DATA_W(8), .OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 4'd0;
  endtask

  task automatic send_beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 8'hA5;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total_cnt++;
    if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000 || out_sum !== 16'd0)
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b ovf=%b sum=%0d required all 0",
               in_ready, out_valid, busy, out_ovf, out_sum);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b vld=%b required 0 0", busy, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_start(4'd1);
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL s1_accum: rdy=%b busy=%b required 1 1", in_ready, busy);
    else pass_cnt++;
    send_beat(8'd12);
    total_cnt++;
    if (out_valid !== 1'b1 || out_sum !== 16'd144 || out_ovf !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL s1_result: vld=%b sum=%0d ovf=%b rdy=%b required 1 144 0 0",
               out_valid, out_sum, out_ovf, in_ready);
    else pass_cnt++;
    handshake();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 16'd144)
      $display("FAIL s1_after_hs: vld=%b busy=%b sum=%0d required 0 0 144",
               out_valid, busy, out_sum);
    else pass_cnt++;
  endtask

  task automatic test_gapped();
    do_start(4'd3);
    send_beat(8'd3);
    in_data = 8'd200;
    tick();
    tick();
    send_beat(8'd4);
    in_data = 8'd99;
    tick();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL s2_mid_run: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    else pass_cnt++;
    send_beat(8'd0);
    total_cnt++;
    if (out_valid !== 1'b1 || out_sum !== 16'd25 || out_ovf !== 1'b0)
      $display("FAIL s2_result: vld=%b sum=%0d ovf=%b required 1 25 0", out_valid, out_sum, out_ovf);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_saturate_back_to_back();
    do_start(4'd2);
    in_valid = 1'b1;
    in_data  = 8'd255;
    tick();
    tick();
    // in_valid stays high past the last beat; nothing more may be accepted
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_sum !== 16'hFFFF || out_ovf !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL s3_saturate: vld=%b sum=%0d ovf=%b rdy=%b required 1 65535 1 0",
               out_valid, out_sum, out_ovf, in_ready);
    else pass_cnt++;
    in_valid = 1'b0;
    handshake();
    do_start(4'd1);
    total_cnt++;
    if (in_ready !== 1'b1 || out_sum !== 16'd0 || out_ovf !== 1'b0)
      $display("FAIL s3_restart_clear: rdy=%b sum=%0d ovf=%b required 1 0 0", in_ready, out_sum, out_ovf);
    else pass_cnt++;
    send_beat(8'd2);
    total_cnt++;
    if (out_valid !== 1'b1 || out_sum !== 16'd4 || out_ovf !== 1'b0)
      $display("FAIL s3_second_run: vld=%b sum=%0d ovf=%b required 1 4 0", out_valid, out_sum, out_ovf);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_len_zero();
    int rdy_seen;
    rdy_seen = 0;
    do_start(4'd0);
    if (in_ready !== 1'b0) rdy_seen++;
    total_cnt++;
    if (out_valid !== 1'b1 || out_sum !== 16'd0 || out_ovf !== 1'b0 || busy !== 1'b1)
      $display("FAIL s4_len0: vld=%b sum=%0d ovf=%b busy=%b required 1 0 0 1",
               out_valid, out_sum, out_ovf, busy);
    else pass_cnt++;
    in_valid = 1'b1;
    in_data  = 8'd9;
    tick();
    if (in_ready !== 1'b0) rdy_seen++;
    in_valid = 1'b0;
    handshake();
    if (in_ready !== 1'b0) rdy_seen++;
    total_cnt++;
    if (rdy_seen !== 0 || out_sum !== 16'd0)
      $display("FAIL s4_no_ready: ready_high_count=%0d sum=%0d required 0 0", rdy_seen, out_sum);
    else pass_cnt++;
  endtask

  task automatic test_hold_done();
    int bad;
    bad = 0;
    do_start(4'd1);
    send_beat(8'd7);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 4'd2;
      in_valid = 1'b1;
      in_data  = 8'd50;
      tick();
      if (out_valid !== 1'b1 || out_sum !== 16'd49 || in_ready !== 1'b0 || out_ovf !== 1'b0) bad++;
    end
    start    = 1'b0;
    len      = 4'd0;
    in_valid = 1'b0;
    total_cnt++;
    if (bad !== 0)
      $display("FAIL s5_hold: unstable_cycles=%0d required 0 (sum=%0d)", bad, out_sum);
    else pass_cnt++;
    handshake();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 16'd49)
      $display("FAIL s5_release: vld=%b busy=%b sum=%0d required 0 0 49", out_valid, busy, out_sum);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 16'd49)
      $display("FAIL s5_idle_out_ready: vld=%b busy=%b sum=%0d required 0 0 49", out_valid, busy, out_sum);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_start(4'd3);
    send_beat(8'd5);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000 || out_sum !== 16'd0)
      $display("FAIL s6_async_reset: rdy=%b vld=%b busy=%b ovf=%b sum=%0d required all 0",
               in_ready, out_valid, busy, out_ovf, out_sum);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL s6_abandoned: vld=%b busy=%b required 0 0", out_valid, busy);
    else pass_cnt++;
    do_start(4'd2);
    send_beat(8'd10);
    send_beat(8'd10);
    total_cnt++;
    if (out_valid !== 1'b1 || out_sum !== 16'd200 || out_ovf !== 1'b0)
      $display("FAIL s6_new_run: vld=%b sum=%0d ovf=%b required 1 200 0", out_valid, out_sum, out_ovf);
    else pass_cnt++;
    handshake();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    start     = 1'b0;
    len       = 4'd0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_gapped();
    test_saturate_back_to_back();
    test_len_zero();
    test_hold_done();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sum_sq_acc.md
SUM_SQ_ACC -- requirements
Module: sum_sq_acc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. The ports SHALL be named clk and rst.
REQ-002 Parameter DATA_W SHALL default to 8 and set the sample width.
REQ-003 Parameter OUT_W SHALL default to 16 and set the result width. This width SHALL match the downstream sqrt num input.
REQ-004 clk SHALL be an input, 1 bit wide: the rising-edge clock.
REQ-005 rst SHALL be an input, 1 bit wide: asynchronous active-high reset.
REQ-006 start SHALL be an input, 1 bit wide: a single-cycle request to begin a run.
REQ-007 len SHALL be an input, 4 bits wide: the number of samples in the run, 0..15, sampled when start is accepted.
REQ-008 in_valid SHALL be an input, 1 bit wide: the sample-valid strobe.
REQ-009 in_data SHALL be an input, DATA_W bits wide: an unsigned sample.
REQ-010 in_ready SHALL be an output, 1 bit wide: the block can accept a sample.
REQ-011 out_valid SHALL be an output, 1 bit wide: the result is available.
REQ-012 out_sum SHALL be an output, OUT_W bits wide: the saturated sum of squares.
REQ-013 out_ovf SHALL be an output, 1 bit wide: saturation occurred during the run.
REQ-014 out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-015 busy SHALL be an output, 1 bit wide: a run is in progress (ACCUM or DONE).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 In IDLE:
- in_ready=0, out_valid=0, busy=0.
- start=1 SHALL latch len into the remaining-sample counter and clear the accumulator and ovf.
- If len is nonzero, the next state SHALL be ACCUM.
- If len=0, the next state SHALL be DONE with out_sum=0.
REQ-018 start SHALL be ignored in ACCUM and DONE. It SHALL NOT restart or alter the run.
REQ-019 In ACCUM:
- in_ready=1 and busy=1.
- A beat SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
- in_data SHALL be ignored on all other cycles.
REQ-020 On each accepted beat:
- Compute sq = in_data*in_data, unsigned, 2*DATA_W bits.
- Compute sum = acc + sq with one extra bit (OUT_W+1 bits).
REQ-021 If the extra bit of sum is set, acc SHALL load all-ones (16'hFFFF) and ovf SHALL set. Otherwise acc SHALL load sum[OUT_W-1:0].
REQ-022 ovf SHALL be sticky within a run. Once acc is saturated, further beats SHALL keep acc at all-ones.
REQ-023 The remaining-sample counter SHALL decrement on each accepted beat. When the last beat is accepted (counter=1), the next state SHALL be DONE.
REQ-024 out_valid SHALL assert on the first cycle after the last beat is accepted, giving one cycle of latency from the final beat.
REQ-025 The beat-accepting edge SHALL drive in_ready low on the following cycle. No beat beyond len SHALL be accepted.
REQ-026 In DONE:
- out_valid=1, in_ready=0, busy=1.
- out_sum and out_ovf SHALL be held stable until accepted.
REQ-027 out_valid=1 and out_ready=1 on an edge SHALL complete the handshake. The next state SHALL be IDLE, and out_valid SHALL be 0 on the following cycle.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 out_sum and out_ovf SHALL retain the last result in IDLE until the next accepted start clears them.
REQ-030 A new start SHALL be honoured only in IDLE, earliest the cycle after the output handshake. There SHALL be no back-to-back overlap of runs.

Reset
REQ-031 rst=1 SHALL immediately, with no clock required, force:
- state to IDLE;
- acc=0, counter=0, ovf=0;
- in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
REQ-032 Reset asserted mid-ACCUM or mid-DONE SHALL abandon the run with no output produced. The first start after deassertion SHALL run normally.

Verification
REQ-033 Scenario 1: len=1, in_data=12 -> out_sum=144, out_ovf=0, out_valid one cycle after the beat.
REQ-034 Scenario 2: len=3, in_data=3,4,0, with in_valid gapped by idle cycles -> out_sum=25, out_ovf=0. Feeding sqrt SHALL yield 5.
REQ-035 Scenario 3: len=2, in_data=255,255 -> out_sum=65535, out_ovf=1. A following run with len=1, in_data=2 -> out_sum=4, out_ovf=0.
REQ-036 Scenario 4: len=0 start -> out_valid on the next cycle, out_sum=0, out_ovf=0, in_ready never high.
REQ-037 Scenario 5: DONE with out_ready low for 5 cycles plus start pulses -> out_sum and out_valid stable, in_ready=0. out_ready=1 -> IDLE on the next cycle.
REQ-038 Scenario 6: len=3, rst asserted after the first beat -> all outputs 0 immediately. A new run with len=2, data 10,10 -> out_sum=200.
